timer_counter_core: RTL and testbench
=====================================

# timer_counter_core

Counting engine of the timer: consumes the control values published by the timer register file (TCR, TCMP, TIER, TISR, THCSR) and produces the free-running 64-bit `mtime`, the one-cycle `int_pending_set` pulse back to the register file, and the interrupt line to the core. It sits directly downstream of the register file and upstream of the interrupt controller. It also handles the counter preload from TDR0/TDR1 writes and the debug halt.

## Interface
Parameters:
- `CNT_WIDTH`, 64: counter and compare width; fixed at 64 for this timer.
- `DIV_WIDTH`, 4: width of the `div_val` field.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `reg_tcr_val`  in  32  bit0 `timer_en`, bit1 `div_en`, bits[11:8] `div_val`.
- `reg_tcmp_val`  in  64  compare value `{TCMP1,TCMP0}`.
- `tier_en`  in  1  TIER bit0, interrupt enable.
- `tisr_pend`  in  1  TISR bit0, current pending flag.
- `halt_req`  in  1  THCSR bit0.
- `dbg_mode`  in  1  CPU in debug mode.
- `cnt_wr_en`  in  2  bit0 loads `mtime[31:0]`, bit1 loads `mtime[63:32]` (APB writes to TDR0/TDR1).
- `cnt_wdata`  in  32  preload data.
- `mtime`  out  64  counter value, registered.
- `int_pending_set`  out  1  one-cycle pulse on compare match.
- `tim_int`  out  1  registered `tier_en & tisr_pend`.
- `halt_ack`  out  1  counter currently frozen by debug halt.

## Operation
- Reset values: `mtime`=0, `int_pending_set`=0, `tim_int`=0, `halt_ack`=0, prescaler=0, match history=0, `timer_en` history=0.
- Tick generation (prescaler):
  - `div_en`=0: tick every cycle.
  - `div_en`=1, `div_val` 0..8: tick every 2^`div_val` cycles.
  - `div_val` 9..15: prohibited; no tick.
- Counting: when `timer_en`=1, not halted, and tick: `mtime` <= `mtime`+1. Wraps from all-ones to 0 with no flag.
- Disable: on the `timer_en` 1→0 transition, `mtime` and prescaler clear to 0 in the next cycle. While `timer_en`=0, `mtime` holds its value.
- Prescaler restart: the prescaler clears on any change of `div_en` or `div_val`. The next tick occurs a full period later.
- Preload:
  - A `cnt_wr_en` bit loads the selected half from `cnt_wdata`.
  - In the same cycle there is no increment.
  - Both bits set loads both halves with the same data.
  - Preload wins over the disable clear.
  - Preload is accepted while halted or disabled.
- Compare:
  - `match` = (`mtime` == `reg_tcmp_val`).
  - `int_pending_set` = `match` & ~`match_q`, registered.
  - A held match produces exactly one pulse.
  - A TCMP write or a preload that creates equality also pulses.
- Halt: `halted` = `dbg_mode` & `halt_req`. While halted, the prescaler and `mtime` freeze. `halt_ack` = `halted` registered. Compare logic keeps running.

## Timing
- Increment visible on `mtime` the cycle after the tick.
- Preload visible the cycle after `cnt_wr_en`.
- `int_pending_set` rises 1 cycle after `mtime` first equals TCMP, lasting 1 cycle.
- `tim_int` follows `tier_en & tisr_pend` with 1-cycle latency.
- `halt_ack` rises/falls 1 cycle after `halted`. The counter freezes in the same cycle `halted` is seen (no increment that edge).
- `rst` asserted mid-count: all outputs go to reset values immediately (asynchronous). Operation resumes at the first edge after deassertion.

## Configuration
- `TIMER_HALT_EN` defined: debug halt logic as described.
- `TIMER_HALT_EN` undefined: `dbg_mode` and `halt_req` ignored, `halt_ack` tied to 0, counter never frozen.

## Structure
- Shared package `timer_pkg` holds:
  - TCR bit positions (`TCR_TIMER_EN_BIT`, `TCR_DIV_EN_BIT`, `TCR_DIV_VAL_LSB/MSB`).
  - `DIV_VAL_MAX`=8.
  - Counter reset value.
- Sub-module `timer_prescaler`: inputs `div_en`, `div_val`, `enable`, `restart`; output `tick`. It contains the 8-bit prescaler counter.
- The counter, compare, and halt logic stay in the top module.

## Test plan
- Reset, `timer_en`=1, `div_en`=0, run 10 cycles → `mtime`=10.
- `div_en`=1, `div_val`=2 → `mtime` increments every 4 cycles. Change `div_val` to 9 → `mtime` stops.
- TCMP=20, count from 0 → single `int_pending_set` pulse the cycle after `mtime`=20. No further pulse while equality holds.
- Preload TDR0=`FFFF_FFFF`, TDR1=`FFFF_FFFF`, enable → `mtime` wraps to 0 after one tick, no error.
- `dbg_mode`=1, `halt_req`=1 mid-count at `mtime`=5 → `mtime` holds 5, `halt_ack`=1 one cycle later. Release → counting resumes from 5.
- `tier_en`=1, `tisr_pend`=1 → `tim_int`=1 one cycle later. Then `timer_en` 1→0 → `mtime`=0 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer: TCR field positions, prescaler limit, counter reset value.
package timer_pkg;

    localparam int TCR_TIMER_EN_BIT = 0;
    localparam int TCR_DIV_EN_BIT   = 1;
    localparam int TCR_DIV_VAL_LSB  = 8;
    localparam int TCR_DIV_VAL_MSB  = 11;

    localparam int DIV_VAL_MAX = 8;

    localparam logic [63:0] CNT_RST_VAL = 64'h0;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: every cycle, or every 2^div_val cycles when divided; no tick for div_val > 8.
// tick is combinational from the registered count; restart clears the count and suppresses that cycle's tick.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_en,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 enable,
    input  logic                 restart,
    output logic                 tick
);

    logic [7:0] cnt;
    logic [8:0] lim;
    logic       div_ok;
    logic       last;

    always_comb begin
        div_ok = (div_val <= DIV_WIDTH'(DIV_VAL_MAX));
        lim    = (9'd1 << div_val) - 9'd1;
        last   = ({1'b0, cnt} == lim);
        tick   = enable & ~restart & (~div_en | (div_ok & last));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (restart) begin
            cnt <= 8'd0;
        end else if (enable && div_en && div_ok) begin
            cnt <= last ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_counter_core.sv
// Timer counting engine: 64-bit mtime with prescaler, TDR preload, compare pulse and interrupt line.
// Debug halt freeze is built only with TIMER_HALT_EN defined; otherwise halt inputs are ignored.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          reg_tcr_val,
    input  logic [CNT_WIDTH-1:0] reg_tcmp_val,
    input  logic                 tier_en,
    input  logic                 tisr_pend,
    input  logic                 halt_req,
    input  logic                 dbg_mode,
    input  logic [1:0]           cnt_wr_en,
    input  logic [31:0]          cnt_wdata,
    output logic [CNT_WIDTH-1:0] mtime,
    output logic                 int_pending_set,
    output logic                 tim_int,
    output logic                 halt_ack
);

    logic                 timer_en;
    logic                 div_en;
    logic [DIV_WIDTH-1:0] div_val;
    logic                 timer_en_q;
    logic                 div_en_q;
    logic [DIV_WIDTH-1:0] div_val_q;
    logic                 halted;
    logic                 dis_clr;
    logic                 restart;
    logic                 tick;
    logic                 match;
    logic                 match_q;
    logic                 unused_tcr;

    assign timer_en   = reg_tcr_val[TCR_TIMER_EN_BIT];
    assign div_en     = reg_tcr_val[TCR_DIV_EN_BIT];
    assign div_val    = reg_tcr_val[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB];
    assign unused_tcr = ^{reg_tcr_val[31:12], reg_tcr_val[7:2]};

`ifdef TIMER_HALT_EN
    assign halted = dbg_mode & halt_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_ack <= 1'b0;
        end else begin
            halt_ack <= halted;
        end
    end
`else
    logic unused_halt;
    assign unused_halt = dbg_mode ^ halt_req;
    assign halted      = 1'b0;
    assign halt_ack    = 1'b0;
`endif

    assign dis_clr = timer_en_q & ~timer_en;
    assign restart = dis_clr | (div_en != div_en_q) | (div_val != div_val_q);
    assign match   = (mtime == reg_tcmp_val);

    timer_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .div_en  (div_en),
        .div_val (div_val),
        .enable  (timer_en & ~halted),
        .restart (restart),
        .tick    (tick)
    );

    // A preload write takes priority over both the disable clear and the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= CNT_RST_VAL[CNT_WIDTH-1:0];
        end else if (|cnt_wr_en) begin
            if (cnt_wr_en[0]) mtime[31:0]           <= cnt_wdata;
            if (cnt_wr_en[1]) mtime[CNT_WIDTH-1:32] <= cnt_wdata;
        end else if (dis_clr) begin
            mtime <= CNT_RST_VAL[CNT_WIDTH-1:0];
        end else if (timer_en && !halted && tick) begin
            mtime <= mtime + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_en_q      <= 1'b0;
            div_en_q        <= 1'b0;
            div_val_q       <= '0;
            match_q         <= 1'b0;
            int_pending_set <= 1'b0;
            tim_int         <= 1'b0;
        end else begin
            timer_en_q      <= timer_en;
            div_en_q        <= div_en;
            div_val_q       <= div_val;
            match_q         <= match;
            int_pending_set <= match & ~match_q;
            tim_int         <= tier_en & tisr_pend;
        end
    end

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core: counting, prescaler, compare pulse, wrap, halt, disable, async reset.
module tb_timer_counter_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_tcr_val;
    logic [63:0] reg_tcmp_val;
    logic        tier_en;
    logic        tisr_pend;
    logic        halt_req;
    logic        dbg_mode;
    logic [1:0]  cnt_wr_en;
    logic [31:0] cnt_wdata;
    logic [63:0] mtime;
    logic        int_pending_set;
    logic        tim_int;
    logic        halt_ack;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_counter_core dut (
        .clk             (clk),
        .rst             (rst),
        .reg_tcr_val     (reg_tcr_val),
        .reg_tcmp_val    (reg_tcmp_val),
        .tier_en         (tier_en),
        .tisr_pend       (tisr_pend),
        .halt_req        (halt_req),
        .dbg_mode        (dbg_mode),
        .cnt_wr_en       (cnt_wr_en),
        .cnt_wdata       (cnt_wdata),
        .mtime           (mtime),
        .int_pending_set (int_pending_set),
        .tim_int         (tim_int),
        .halt_ack        (halt_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        reg_tcr_val  = 32'h0;
        reg_tcmp_val = 64'd1000;
        tier_en      = 1'b0;
        tisr_pend    = 1'b0;
        halt_req     = 1'b0;
        dbg_mode     = 1'b0;
        cnt_wr_en    = 2'b00;
        cnt_wdata    = 32'h0;
        #3;
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_ips", {63'd0, int_pending_set}, 64'd0);
        chk("rst_tim_int", {63'd0, tim_int}, 64'd0);
        chk("rst_halt_ack", {63'd0, halt_ack}, 64'd0);
        step(1);
        rst = 1'b0;

        // Undivided counting
        reg_tcr_val = 32'h0000_0001;
        step(10);
        chk("run10", mtime, 64'd10);

        // div_val=2: restart edge, then one tick every 4 edges
        reg_tcr_val = 32'h0000_0203;
        step(4);
        chk("div4_hold", mtime, 64'd10);
        step(1);
        chk("div4_t1", mtime, 64'd11);
        step(4);
        chk("div4_t2", mtime, 64'd12);
        step(4);
        chk("div4_t3", mtime, 64'd13);
        reg_tcr_val = 32'h0000_0903;
        step(20);
        chk("div9_stop", mtime, 64'd13);

        // Compare: preload 0, TCMP=20, count up
        reg_tcr_val  = 32'h0000_0001;
        reg_tcmp_val = 64'd20;
        cnt_wr_en    = 2'b11;
        cnt_wdata    = 32'h0;
        step(1);
        cnt_wr_en = 2'b00;
        chk("preload0", mtime, 64'd0);
        step(19);
        chk("cmp_pre", mtime, 64'd19);
        step(1);
        chk("cmp_eq_mtime", mtime, 64'd20);
        chk("cmp_eq_ips", {63'd0, int_pending_set}, 64'd0);
        reg_tcr_val = 32'h0000_0903;
        step(1);
        chk("cmp_pulse", {63'd0, int_pending_set}, 64'd1);
        chk("cmp_held_mtime", mtime, 64'd20);
        step(1);
        chk("cmp_pulse_end", {63'd0, int_pending_set}, 64'd0);
        step(7);
        chk("cmp_no_repeat", {63'd0, int_pending_set}, 64'd0);

        // Wrap from all-ones
        cnt_wr_en   = 2'b11;
        cnt_wdata   = 32'hFFFF_FFFF;
        reg_tcr_val = 32'h0000_0001;
        step(1);
        cnt_wr_en = 2'b00;
        chk("preload_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1);
        chk("wrap0", mtime, 64'd0);
        step(1);
        chk("wrap1", mtime, 64'd1);

        // Debug halt at mtime=5
        cnt_wr_en = 2'b11;
        cnt_wdata = 32'h0;
        step(1);
        cnt_wr_en = 2'b00;
        step(5);
        chk("halt_pre", mtime, 64'd5);
        dbg_mode = 1'b1;
        halt_req = 1'b1;
        chk("halt_ack_pre", {63'd0, halt_ack}, 64'd0);
        step(1);
`ifdef TIMER_HALT_EN
        chk("halt_freeze", mtime, 64'd5);
        chk("halt_ack_on", {63'd0, halt_ack}, 64'd1);
        step(3);
        chk("halt_hold", mtime, 64'd5);
        dbg_mode = 1'b0;
        step(1);
        chk("halt_resume", mtime, 64'd6);
        chk("halt_ack_off", {63'd0, halt_ack}, 64'd0);
`else
        chk("nohalt_run", mtime, 64'd6);
        chk("nohalt_ack", {63'd0, halt_ack}, 64'd0);
        step(3);
        chk("nohalt_run3", mtime, 64'd9);
        dbg_mode = 1'b0;
        step(1);
        chk("nohalt_rel", mtime, 64'd10);
        chk("nohalt_ack2", {63'd0, halt_ack}, 64'd0);
`endif
        halt_req = 1'b0;

        // Interrupt line, then disable clear
        tier_en   = 1'b1;
        tisr_pend = 1'b1;
        chk("tim_int_pre", {63'd0, tim_int}, 64'd0);
        step(1);
        chk("tim_int_on", {63'd0, tim_int}, 64'd1);
        reg_tcr_val = 32'h0;
        step(1);
        chk("disable_clr", mtime, 64'd0);
        step(3);
        chk("disable_hold", mtime, 64'd0);
        tisr_pend = 1'b0;
        step(1);
        chk("tim_int_off", {63'd0, tim_int}, 64'd0);

        // Async reset mid-count
        tisr_pend   = 1'b1;
        reg_tcr_val = 32'h0000_0001;
        step(4);
        chk("arst_pre", mtime, 64'd4);
        chk("arst_pre_int", {63'd0, tim_int}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mtime", mtime, 64'd0);
        chk("arst_int", {63'd0, tim_int}, 64'd0);
        step(1);
        rst = 1'b0;
        step(2);
        chk("arst_resume", mtime, 64'd2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
